// File: rtl/grouped_update_pkg.sv
// Shared types and defaults for the grouped Gibbs-sweep update scheduler.
// Pure declarations: no latency, no backpressure.
// run_cycles() gives the start-edge to DONE distance for a run of n sweeps.
package grouped_update_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_NUM_GROUPS    = 5;
  localparam int DEF_GROUP_W       = 4;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_GAP_CYCLES    = 1;
  localparam int DEF_SWEEP_W       = 16;

  // No gap follows the last group, hence the -1 on the gap term.
  function automatic int run_cycles(input int n, input int groups, input int settle, input int gap);
    return n * groups * settle + (n * groups - 1) * gap;
  endfunction

endpackage

// File: rtl/grouped_update_scheduler_dwell_timer.sv
// Loadable down-counter that times both the settle and the gap intervals.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// No backpressure: en simply freezes the count, and the count holds at zero.
module dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/grouped_update_scheduler.sv
// Steps the color-group index through NUM_GROUPS groups per sweep for a Gibbs run.
// Latency: first group valid the cycle after start; done after run_cycles() cycles.
// No backpressure: runs free once started; only stop or reset interrupt it.
module grouped_update_scheduler
  import grouped_update_pkg::*;
#(
  parameter int NUM_GROUPS    = DEF_NUM_GROUPS,
  parameter int GROUP_W       = DEF_GROUP_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int SWEEP_W       = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic               stop,
  output logic [0:GROUP_W-1] group_EN,
  output logic               group_valid,
  output logic               sweep_tick,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic               busy,
  output logic               done
);

  localparam int DWELL_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int DW        = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

  localparam logic [DW-1:0]      SETTLE_LOAD = DW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0]      GAP_LOAD    = DW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [GROUP_W-1:0] LAST_GROUP  = GROUP_W'(NUM_GROUPS - 1);

  state_t             state, state_n;
  logic [GROUP_W-1:0] group_q, group_n;
  logic [SWEEP_W-1:0] count_q, count_n;
  logic [SWEEP_W-1:0] target_q, target_n;
  logic               tick_q, tick_n;

  logic               tmr_load, tmr_en, tmr_zero;
  logic [DW-1:0]      tmr_val;

  logic               last_grp, last_sweep;
  logic [GROUP_W-1:0] adv_group;
  logic [SWEEP_W-1:0] adv_count;

  dwell_timer #(.W(DW)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Advancing past the last group wraps the index and closes a sweep.
  assign last_grp   = (group_q == LAST_GROUP);
  assign last_sweep = (count_q == (target_q - 1'b1));
  assign adv_group  = last_grp ? '0 : (group_q + 1'b1);
  assign adv_count  = (last_grp && (count_q != '1)) ? (count_q + 1'b1) : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      group_q  <= '0;
      count_q  <= '0;
      target_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_n;
      group_q  <= group_n;
      count_q  <= count_n;
      target_q <= target_n;
      tick_q   <= tick_n;
    end
  end

  always_comb begin
    state_n  = state;
    group_n  = group_q;
    count_n  = count_q;
    target_n = target_q;
    tick_n   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LOAD;
    tmr_en   = 1'b0;

    case (state)
      IDLE: begin
        group_n = '0;
        if (start) begin
          target_n = num_sweeps;
          count_n  = '0;
          if (num_sweeps != '0) begin
            state_n  = UPDATE;
            tmr_load = 1'b1;
          end else begin
            state_n = DONE;
          end
        end
      end

      UPDATE: begin
        tmr_en = 1'b1;
        if (stop) begin
          state_n = IDLE;
          group_n = '0;
        end else if (tmr_zero) begin
          if (last_grp && last_sweep) begin
            state_n = DONE;
            group_n = adv_group;
            count_n = adv_count;
            tick_n  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            // The finished group's index is held through the gap.
            state_n  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end else begin
            group_n  = adv_group;
            count_n  = adv_count;
            tick_n   = last_grp;
            tmr_load = 1'b1;
          end
        end
      end

      GAP: begin
        tmr_en = 1'b1;
        if (stop) begin
          state_n = IDLE;
          group_n = '0;
        end else if (tmr_zero) begin
          state_n  = UPDATE;
          group_n  = adv_group;
          count_n  = adv_count;
          tick_n   = last_grp;
          tmr_load = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
        group_n = '0;
      end

      default: begin
        state_n = IDLE;
        group_n = '0;
      end
    endcase
  end

  assign group_EN    = group_q;
  assign group_valid = (state == UPDATE);
  assign sweep_tick  = tick_q;
  assign sweep_count = count_q;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_grouped_update_scheduler.sv
// Directed bench: a vector table for the nominal run plus hand-written corner sequences.
module tb_grouped_update_scheduler;
  import grouped_update_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, stop0, start1, stop1;
  logic [15:0] ns0, ns1;
  logic [0:3]  grp0, grp1;
  logic        vld0, tick0, done0, busy0;
  logic        vld1, tick1, done1, busy1;
  logic [15:0] cnt0, cnt1;

  grouped_update_scheduler #(
    .NUM_GROUPS(5), .GROUP_W(4), .SETTLE_CYCLES(4), .GAP_CYCLES(1), .SWEEP_W(16)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .num_sweeps(ns0), .stop(stop0),
    .group_EN(grp0), .group_valid(vld0), .sweep_tick(tick0), .sweep_count(cnt0),
    .busy(busy0), .done(done0)
  );

  grouped_update_scheduler #(
    .NUM_GROUPS(5), .GROUP_W(4), .SETTLE_CYCLES(4), .GAP_CYCLES(0), .SWEEP_W(16)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .num_sweeps(ns1), .stop(stop1),
    .group_EN(grp1), .group_valid(vld1), .sweep_tick(tick1), .sweep_count(cnt1),
    .busy(busy1), .done(done1)
  );

  typedef struct {
    int cyc;
    int grp;
    int vld;
    int tick;
    int done;
    int busy;
    int cnt;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl[NV];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge; returns at the following falling edge, where outputs are sampled.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the sample point just after the accepting edge (t=0).
  task automatic start_u0(input int n);
    start0 = 1'b1;
    ns0    = 16'(n);
    cyc();
    start0 = 1'b0;
  endtask

  initial begin
    int done_at, ticks, vcyc, first_low, dones;

    tbl[0]  = '{0,  0, 1, 0, 0, 1, 0};
    tbl[1]  = '{3,  0, 1, 0, 0, 1, 0};
    tbl[2]  = '{4,  0, 0, 0, 0, 1, 0};
    tbl[3]  = '{5,  1, 1, 0, 0, 1, 0};
    tbl[4]  = '{19, 3, 0, 0, 0, 1, 0};
    tbl[5]  = '{24, 4, 0, 0, 0, 1, 0};
    tbl[6]  = '{25, 0, 1, 1, 0, 1, 1};
    tbl[7]  = '{26, 0, 1, 0, 0, 1, 1};
    tbl[8]  = '{44, 3, 0, 0, 0, 1, 1};
    tbl[9]  = '{48, 4, 1, 0, 0, 1, 1};
    tbl[10] = '{49, 0, 0, 1, 1, 1, 2};
    tbl[11] = '{50, 0, 0, 0, 0, 0, 2};

    rst_n  = 1'b0;
    start0 = 1'b0; stop0 = 1'b0; ns0 = '0;
    start1 = 1'b0; stop1 = 1'b0; ns1 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_grp",   int'(grp0),  0);
    check("rst_valid", int'(vld0),  0);
    check("rst_tick",  int'(tick0), 0);
    check("rst_done",  int'(done0), 0);
    check("rst_busy",  int'(busy0), 0);
    check("rst_count", int'(cnt0),  0);
    rst_n = 1'b1;
    cyc();

    // Nominal: 2 sweeps, default timing, checked against the vector table.
    start_u0(2);
    done_at = -1; ticks = 0; vcyc = 0;
    for (int t = 0; t <= 50; t++) begin
      if (t > 0) cyc();
      if (tick0) ticks++;
      if (vld0) vcyc++;
      if (done0 && done_at < 0) done_at = t;
      for (int i = 0; i < NV; i++) begin
        if (tbl[i].cyc == t) begin
          check($sformatf("nom_grp_t%0d", t),   int'(grp0),  tbl[i].grp);
          check($sformatf("nom_vld_t%0d", t),   int'(vld0),  tbl[i].vld);
          check($sformatf("nom_tick_t%0d", t),  int'(tick0), tbl[i].tick);
          check($sformatf("nom_done_t%0d", t),  int'(done0), tbl[i].done);
          check($sformatf("nom_busy_t%0d", t),  int'(busy0), tbl[i].busy);
          check($sformatf("nom_count_t%0d", t), int'(cnt0),  tbl[i].cnt);
        end
      end
    end
    check("nom_done_cycle", done_at, run_cycles(2, 5, 4, 1));
    check("nom_ticks", ticks, 2);
    check("nom_valid_cycles", vcyc, 40);

    // Zero gap: one sweep, valid continuously for 20 cycles.
    start1 = 1'b1; ns1 = 16'd1;
    cyc();
    start1 = 1'b0;
    done_at = -1; first_low = -1;
    for (int t = 0; t <= 22; t++) begin
      if (t > 0) cyc();
      if (!vld1 && first_low < 0) first_low = t;
      if (done1 && done_at < 0) done_at = t;
      if ((t % 4) == 0 && t < 20) check($sformatf("nogap_grp_t%0d", t), int'(grp1), t / 4);
    end
    check("nogap_first_invalid", first_low, 20);
    check("nogap_done_cycle", done_at, run_cycles(1, 5, 4, 0));
    check("nogap_count", int'(cnt1), 1);

    // Zero sweeps: immediate DONE, nothing valid.
    cyc();
    start_u0(0);
    check("zero_done",  int'(done0), 1);
    check("zero_busy",  int'(busy0), 1);
    check("zero_valid", int'(vld0),  0);
    check("zero_count", int'(cnt0),  0);
    cyc();
    check("zero_done_after", int'(done0), 0);
    check("zero_busy_after", int'(busy0), 0);

    // Stop in the gap after the first group of sweep 2 of 3.
    cyc();
    start_u0(3);
    dones = 0;
    for (int t = 1; t <= 29; t++) begin
      cyc();
      if (done0) dones++;
    end
    check("stop_pre_valid", int'(vld0), 0);
    check("stop_pre_grp",   int'(grp0), 0);
    check("stop_pre_count", int'(cnt0), 1);
    stop0 = 1'b1;
    cyc();
    stop0 = 1'b0;
    check("stop_busy",  int'(busy0), 0);
    check("stop_valid", int'(vld0),  0);
    check("stop_tick",  int'(tick0), 0);
    check("stop_count", int'(cnt0),  1);
    for (int t = 0; t < 4; t++) begin
      if (done0) dones++;
      cyc();
    end
    check("stop_no_done", dones, 0);
    start_u0(1);
    done_at = -1;
    for (int t = 0; t <= 30; t++) begin
      if (t > 0) cyc();
      if (done0 && done_at < 0) begin
        done_at = t;
        check("restart_count", int'(cnt0), 1);
      end
    end
    check("restart_done_cycle", done_at, run_cycles(1, 5, 4, 1));

    // Start re-pulsed mid-run with a different count.
    start_u0(2);
    done_at = -1; ticks = 0;
    for (int t = 0; t <= 52; t++) begin
      if (t > 0) cyc();
      if (tick0) ticks++;
      if (done0 && done_at < 0) begin
        done_at = t;
        check("busy_start_count", int'(cnt0), 2);
      end
      if (t == 10) begin start0 = 1'b1; ns0 = 16'd7; end
      if (t == 11) start0 = 1'b0;
      if (t == 52) check("busy_start_idle", int'(busy0), 0);
    end
    check("busy_start_done_cycle", done_at, 49);
    check("busy_start_ticks", ticks, 2);

    // Asynchronous reset during group 2 of sweep 2.
    start_u0(2);
    for (int t = 1; t <= 36; t++) cyc();
    check("rmid_pre_grp",   int'(grp0), 2);
    check("rmid_pre_valid", int'(vld0), 1);
    check("rmid_pre_count", int'(cnt0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_grp",   int'(grp0),  0);
    check("rmid_valid", int'(vld0),  0);
    check("rmid_tick",  int'(tick0), 0);
    check("rmid_done",  int'(done0), 0);
    check("rmid_busy",  int'(busy0), 0);
    check("rmid_count", int'(cnt0),  0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int t = 0; t < 20; t++) begin
      cyc();
      if (done0 || busy0) dones++;
    end
    check("rmid_idle_after", dones, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grouped_update_scheduler.md
Name: grouped_update_scheduler

Overview:
- Drives the group index that selects one color group of p-bits at a time for a graph-colored Gibbs sweep; it is the initiator for the grouped update-order lookup, which turns the index into a per-p-bit enable mask.
- Steps through groups 0..NUM_GROUPS-1 for a requested number of sweeps.
- Holds each group enabled for SETTLE_CYCLES cycles, then inserts a non-overlap gap.
- Reports progress and signals completion to the top-level controller.

Parameters:
- NUM_GROUPS, 5, number of color groups; legal range 2..2^GROUP_W.
- GROUP_W, 4, width of the group index bus.
- SETTLE_CYCLES, 4, cycles each group stays enabled; must be >=1.
- GAP_CYCLES, 1, cycles with no group enabled between consecutive groups; may be 0.
- SWEEP_W, 16, width of the sweep count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_sweeps  in  SWEEP_W  sweeps requested; latched when start is accepted.
- stop  in  1  abort the current run.
- group_EN  out  [0:GROUP_W-1]  current group index, fed to the update-order lookup.
- group_valid  out  1  high when group_EN must actually enable p-bits; downstream gates the mask with it.
- sweep_tick  out  1  one-cycle pulse at the end of each completed sweep.
- sweep_count  out  SWEEP_W  number of sweeps completed in this run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - group_EN=0, group_valid=0, sweep_tick=0, sweep_count=0, busy=0, done=0.
  - Internal dwell counter and latched sweep target cleared.
  - Reset mid-run aborts immediately; no done pulse.
- States: IDLE, UPDATE, GAP, DONE.
- IDLE:
  - start=1 with num_sweeps>0 -> UPDATE on the next cycle, with group_EN=0, sweep_count=0, dwell=SETTLE_CYCLES-1.
  - start=1 with num_sweeps=0 -> DONE; no group is ever valid.
- UPDATE:
  - group_valid=1; dwell decrements each cycle.
  - When dwell=0 and this is the last group of the last sweep -> DONE.
  - Otherwise, when dwell=0 -> GAP if GAP_CYCLES>0, else directly to the next group in UPDATE.
- GAP:
  - group_valid=0; group_EN holds the finished group's index.
  - Lasts GAP_CYCLES cycles, then UPDATE with the next group.
- Group advance:
  - group_EN increments.
  - When group_EN=NUM_GROUPS-1 it wraps to 0, sweep_count increments, and sweep_tick pulses.
  - sweep_tick pulses in the same cycle the wrap is registered, including the final sweep (registered on entry to DONE).
- DONE:
  - done=1 and busy=1 for exactly one cycle, group_valid=0, then IDLE.
  - sweep_count holds its final value until the next accepted start.
  - group_EN returns to 0 in IDLE.
- stop:
  - stop=1 in UPDATE or GAP -> IDLE next cycle; group_valid=0, no done pulse, no sweep_tick.
  - sweep_count keeps the number of sweeps completed before the abort.
  - stop has priority over any other transition in the same cycle.
  - stop in IDLE or DONE is ignored; DONE still pulses.
- start while busy is ignored; num_sweeps is not re-sampled.
- Exactly one group is valid at any time; group_valid is never high for an index >= NUM_GROUPS.
- Timing:
  - Run length from the accepted start edge to the DONE cycle = N*NUM_GROUPS*SETTLE_CYCLES + (N*NUM_GROUPS-1)*GAP_CYCLES cycles.
  - No gap follows the last group.
- sweep_count saturates at all-ones; unreachable because it can never exceed num_sweeps.

Decomposition:
- Package grouped_update_pkg:
  - state enum (IDLE, UPDATE, GAP, DONE).
  - Default parameter constants.
  - Helper function for the run-length formula, used by the bench.
- Sub-module dwell_timer: a loadable down-counter with load, enable and zero flag. Reused for both SETTLE and GAP intervals, loaded with SETTLE_CYCLES-1 or GAP_CYCLES-1.

Test Plan:
- Reset mid-run: rst_n low during UPDATE of group 2 -> all outputs 0 asynchronously; after release, IDLE with busy=0.
- Nominal run (defaults), start with num_sweeps=2:
  - group_EN sequence 0,1,2,3,4,0,1,2,3,4, each valid for 4 cycles, 1-cycle gaps.
  - sweep_tick pulses twice.
  - done pulses 49 cycles after the start edge; sweep_count=2.
- GAP_CYCLES=0, num_sweeps=1 -> group_valid continuously high for 20 cycles, group_EN steps every 4 cycles, done at cycle 20.
- num_sweeps=0 -> done pulses on the cycle after start; group_valid never high; sweep_count=0.
- stop asserted during GAP after sweep 1 of 3 -> IDLE next cycle, no done pulse, sweep_count=1. A new start with num_sweeps=1 then completes normally.
- start pulsed again while busy, with num_sweeps changed to 7 -> ignored; the run finishes with the original count, and done fires at the original predicted cycle.
